// File: rtl/instrumented_ripple_adder_wrap.sv
// Caravel-style wrapped ripple-carry adder with an inverting ring-oscillator loop.
// The loop runs from the selected sum taps, through chain_out, back into the selected A bits.
module instrumented_ripple_adder_wrap #(
    parameter int WIDTH = 32
) (
    input  logic        wb_clk_i,
    input  logic        active,
    input  logic [31:0] la1_data_in,
    input  logic [31:0] la2_data_in,
    input  logic [31:0] la3_data_in,
    input  logic [37:0] io_in,
    input  logic [31:0] la1_oenb,
    input  logic [31:0] la2_oenb,
    input  logic [31:0] la3_oenb,
    output logic [31:0] la1_data_out,
    output logic [31:0] la2_data_out,
    output logic [31:0] la3_data_out,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    logic rst_n, load_op, load_cfg, load_tap, run;
    assign rst_n    = la1_data_in[0];
    assign load_op  = la1_data_in[1];
    assign load_cfg = la1_data_in[2];
    assign load_tap = la1_data_in[3];
    assign run      = la1_data_in[4];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, la1_data_in[31:5], io_in, la1_oenb, la2_oenb, la3_oenb};

    logic [WIDTH-1:0] a_input_q, a_input_d;
    logic [WIDTH-1:0] b_input_q, b_input_d;
    logic [WIDTH-1:0] a_input_ext_bit_b_q, a_input_ext_bit_b_d;
    logic [WIDTH-1:0] a_input_ring_bit_b_q, a_input_ring_bit_b_d;
    logic [WIDTH-1:0] s_output_bit_b_q, s_output_bit_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] toggle_cnt_q, toggle_cnt_d;
    logic             carry_out_q, carry_out_d;
    logic             chain_out_q, chain_out_d;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             tap;

    // Ring selection wins over external selection; a bit with neither selected reads 0.
    always_comb begin
        a_eff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!a_input_ring_bit_b_q[i])
                a_eff[i] = chain_out_q;
            else if (!a_input_ext_bit_b_q[i])
                a_eff[i] = a_input_q[i];
        end
    end

    // Explicit full-adder stages so the carry genuinely ripples bit by bit.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a_eff[i] ^ b_input_q[i] ^ carry;
            carry  = (a_eff[i] & b_input_q[i]) | (carry & (a_eff[i] ^ b_input_q[i]));
        end
        carry_out = carry;
    end

    assign tap = |(sum & ~s_output_bit_b_q);

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no latch is inferred.
        a_input_d            = a_input_q;
        b_input_d            = b_input_q;
        a_input_ext_bit_b_d  = a_input_ext_bit_b_q;
        a_input_ring_bit_b_d = a_input_ring_bit_b_q;
        s_output_bit_b_d     = s_output_bit_b_q;
        chain_out_d          = chain_out_q;
        toggle_cnt_d         = toggle_cnt_q;
        sum_d                = sum;
        carry_out_d          = carry_out;

        if (load_op) begin
            a_input_d = la2_data_in[WIDTH-1:0];
            b_input_d = la3_data_in[WIDTH-1:0];
        end
        if (load_cfg) begin
            a_input_ext_bit_b_d  = la2_data_in[WIDTH-1:0];
            a_input_ring_bit_b_d = la3_data_in[WIDTH-1:0];
        end
        if (load_tap)
            s_output_bit_b_d = la2_data_in[WIDTH-1:0];

        if (run) begin
            chain_out_d = ~tap;
            if (~tap != chain_out_q)
                toggle_cnt_d = toggle_cnt_q + WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            a_input_q            <= '0;
            b_input_q            <= '0;
            a_input_ext_bit_b_q  <= '0;
            a_input_ring_bit_b_q <= '1;
            s_output_bit_b_q     <= '1;
            sum_q                <= '0;
            carry_out_q          <= 1'b0;
            chain_out_q          <= 1'b0;
            toggle_cnt_q         <= '0;
        end else begin
            a_input_q            <= a_input_d;
            b_input_q            <= b_input_d;
            a_input_ext_bit_b_q  <= a_input_ext_bit_b_d;
            a_input_ring_bit_b_q <= a_input_ring_bit_b_d;
            s_output_bit_b_q     <= s_output_bit_b_d;
            sum_q                <= sum_d;
            carry_out_q          <= carry_out_d;
            chain_out_q          <= chain_out_d;
            toggle_cnt_q         <= toggle_cnt_d;
        end
    end

    always_comb begin
        la1_data_out = '0;
        la2_data_out = '0;
        la3_data_out = '0;
        io_out       = '0;
        io_oeb       = '1;
        if (active) begin
            la1_data_out = 32'(sum_q);
            la2_data_out = 32'(toggle_cnt_q);
            la3_data_out = {30'b0, carry_out_q, chain_out_q};
            io_out       = {29'b0, chain_out_q, sum_q[7:0]};
            io_oeb       = {29'h1FFF_FFFF, 9'b0};
        end
    end

endmodule

// File: tb/tb_instrumented_ripple_adder_wrap.sv
// Self-checking bench: directed test-plan scenarios followed by random control/data,
// all compared every cycle against an arithmetic reference model.
module tb_instrumented_ripple_adder_wrap;

    localparam logic [4:0] C_RST  = 5'b00000;
    localparam logic [4:0] C_IDLE = 5'b00001;
    localparam logic [4:0] C_OP   = 5'b00011;
    localparam logic [4:0] C_CFG  = 5'b00101;
    localparam logic [4:0] C_TAP  = 5'b01001;
    localparam logic [4:0] C_RUN  = 5'b10001;

    logic        wb_clk_i;
    logic        active;
    logic [31:0] la1_data_in, la2_data_in, la3_data_in;
    logic [37:0] io_in;
    logic [31:0] la1_oenb, la2_oenb, la3_oenb;
    logic [31:0] la1_data_out, la2_data_out, la3_data_out;
    logic [37:0] io_out, io_oeb;

    int n_vec  = 0;
    int n_fail = 0;

    instrumented_ripple_adder_wrap dut (
        .wb_clk_i     (wb_clk_i),
        .active       (active),
        .la1_data_in  (la1_data_in),
        .la2_data_in  (la2_data_in),
        .la3_data_in  (la3_data_in),
        .io_in        (io_in),
        .la1_oenb     (la1_oenb),
        .la2_oenb     (la2_oenb),
        .la3_oenb     (la3_oenb),
        .la1_data_out (la1_data_out),
        .la2_data_out (la2_data_out),
        .la3_data_out (la3_data_out),
        .io_out       (io_out),
        .io_oeb       (io_oeb)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Reference model state
    logic [31:0] m_a, m_b, m_ext, m_ring, m_tapm, m_sum, m_cnt;
    logic        m_carry, m_chain;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] a_eff, tap_bits;
        logic [32:0] full;
        logic        new_chain;
        if (!la1_data_in[0]) begin
            m_a = 0; m_b = 0; m_ext = 0; m_ring = '1; m_tapm = '1;
            m_sum = 0; m_carry = 0; m_chain = 0; m_cnt = 0;
        end else begin
            a_eff    = ({32{m_chain}} & ~m_ring) | (m_a & ~m_ext & m_ring);
            full     = {1'b0, a_eff} + {1'b0, m_b};
            tap_bits = full[31:0] & ~m_tapm;
            m_sum    = full[31:0];
            m_carry  = full[32];
            if (la1_data_in[4]) begin
                new_chain = (tap_bits == 0);
                if (new_chain != m_chain) m_cnt = m_cnt + 1;
                m_chain = new_chain;
            end
            if (la1_data_in[1]) begin m_a = la2_data_in; m_b = la3_data_in; end
            if (la1_data_in[2]) begin m_ext = la2_data_in; m_ring = la3_data_in; end
            if (la1_data_in[3]) m_tapm = la2_data_in;
        end
    endtask

    task automatic compare_all();
        if (active) begin
            check("la1_sum", {32'b0, la1_data_out}, {32'b0, m_sum});
            check("la2_cnt", {32'b0, la2_data_out}, {32'b0, m_cnt});
            check("la3_status", {32'b0, la3_data_out}, {62'b0, m_carry, m_chain});
            check("io_out", {26'b0, io_out}, {26'b0, 29'b0, m_chain, m_sum[7:0]});
            check("io_oeb", {26'b0, io_oeb}, {26'b0, 38'h3F_FFFF_FE00});
        end else begin
            check("la1_gated", {32'b0, la1_data_out}, 64'b0);
            check("la2_gated", {32'b0, la2_data_out}, 64'b0);
            check("la3_gated", {32'b0, la3_data_out}, 64'b0);
            check("io_out_gated", {26'b0, io_out}, 64'b0);
            check("io_oeb_gated", {26'b0, io_oeb}, {26'b0, {38{1'b1}}});
        end
    endtask

    // Drive at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic act);
        la1_data_in = {27'($urandom), ctl};
        la2_data_in = a;
        la3_data_in = b;
        active      = act;
        io_in       = {6'($urandom), 32'($urandom)};
        la1_oenb    = $urandom;
        la2_oenb    = $urandom;
        la3_oenb    = $urandom;
        @(posedge wb_clk_i);
        model_edge();
        @(negedge wb_clk_i);
        compare_all();
    endtask

    initial begin
        logic [4:0]  ctl;
        logic [31:0] ra, rb;
        m_a = 0; m_b = 0; m_ext = 0; m_ring = '1; m_tapm = '1;
        m_sum = 0; m_carry = 0; m_chain = 0; m_cnt = 0;
        active = 1'b1; la1_data_in = 0; la2_data_in = 0; la3_data_in = 0;
        io_in = 0; la1_oenb = 0; la2_oenb = 0; la3_oenb = 0;
        @(negedge wb_clk_i);

        // Reset and release
        step(C_RST, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        step(C_RST, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        check("rst_la1", {32'b0, la1_data_out}, 64'h0);
        check("rst_la2", {32'b0, la2_data_out}, 64'h0);
        check("rst_la3", {32'b0, la3_data_out}, 64'h0);
        check("rst_oeb", {26'b0, io_oeb}, 64'h3F_FFFF_FE00);

        // Plain add with reset-default masks
        step(C_OP, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        check("add_latency", {32'b0, la1_data_out}, 64'h0);
        step(C_IDLE, 0, 0, 1'b1);
        check("add_sum", {32'b0, la1_data_out}, 64'h100);
        check("add_io_low", {56'b0, io_out[7:0]}, 64'h0);
        check("add_carry", {63'b0, la3_data_out[1]}, 64'h0);

        // Overflow
        step(C_OP, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        check("ovf_sum", {32'b0, la1_data_out}, 64'h0);
        check("ovf_status", {32'b0, la3_data_out}, 64'h2);

        // Ring loop through bit 15
        step(C_CFG, 32'h0000_0000, 32'hFFFF_7FFF, 1'b1);
        step(C_TAP, 32'hFFFF_7FFF, 0, 1'b1);
        step(C_OP, 0, 0, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(C_RUN, 0, 0, 1'b1);
            check("ring_chain", {63'b0, la3_data_out[0]}, {63'b0, k[0]});
        end
        check("ring_cnt", {32'b0, la2_data_out}, 64'd10);
        step(C_IDLE, 0, 0, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        check("ring_hold", {32'b0, la2_data_out}, 64'd10);

        // Inactive gating
        step(C_OP, 32'h0000_1234, 32'h0000_1111, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        step(C_IDLE, 0, 0, 1'b0);
        check("gate_la1", {32'b0, la1_data_out}, 64'h0);
        check("gate_oeb", {26'b0, io_oeb}, {26'b0, {38{1'b1}}});
        step(C_IDLE, 0, 0, 1'b1);
        check("gate_restore", {32'b0, la1_data_out}, 64'h2345);

        // Mid-run reset
        step(C_RUN, 0, 0, 1'b1);
        step(C_RUN, 0, 0, 1'b1);
        step(C_RUN, 0, 0, 1'b1);
        check("mid_cnt", {32'b0, la2_data_out}, 64'd13);
        step(5'b10000, 0, 0, 1'b1);
        check("mid_rst_cnt", {32'b0, la2_data_out}, 64'h0);
        check("mid_rst_chain", {63'b0, la3_data_out[0]}, 64'h0);
        step(C_OP, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        step(C_IDLE, 0, 0, 1'b1);
        check("mid_masks", {32'b0, la1_data_out}, 64'h100);

        // Random control and data
        for (int n = 0; n < 600; n++) begin
            ctl[0] = ($urandom_range(0, 31) != 0);
            ctl[1] = ($urandom_range(0, 3) == 0);
            ctl[2] = ($urandom_range(0, 7) == 0);
            ctl[3] = ($urandom_range(0, 7) == 0);
            ctl[4] = ($urandom_range(0, 1) == 0);
            ra = $urandom;
            rb = $urandom;
            if (ctl[2] || ctl[3]) begin
                if ($urandom_range(0, 1) == 0) ra = ra | ~(32'h1 << $urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) rb = rb | ~(32'h1 << $urandom_range(0, 31));
            end
            step(ctl, ra, rb, $urandom_range(0, 7) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
